// File: rtl/matmul_engine.sv
// matmul_engine
// Streams A (m x k) and B (k x n) from two synchronous-read memories and writes
// C = A * B (signed fixed point, row-major) to an output memory, one element at
// a time: k fetch cycles, RD_LAT drain cycles, one write cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a job (accepted in IDLE only)
//   m, n, k, relu_en         job dimensions and ReLU mode, latched at start
//   input_addr/input_data    A memory read port (data RD_LAT cycles after addr)
//   weight_addr/weight_data  B memory read port (data RD_LAT cycles after addr)
//   output_addr/output_data  C write port, qualified by write_enable
//   busy, done, overflow     status; overflow is sticky until next start
module matmul_engine #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int DIM_W     = 10,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    input  logic [DIM_W-1:0]  k,
    input  logic              relu_en,
    output logic [ADDR_W-1:0] input_addr,
    input  logic [DATA_W-1:0] input_data,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight_data,
    output logic [ADDR_W-1:0] output_addr,
    output logic [DATA_W-1:0] output_data,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int AW2    = 2 * DIM_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [DIM_W-1:0]          m_q, m_d, n_q, n_d, k_q, k_d;
    logic [DIM_W-1:0]          i_q, i_d, j_q, j_d, p_q, p_d;
    logic                      relu_q, relu_d;
    logic [1:0]                drain_q, drain_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [RD_LAT-1:0]         valid_q, valid_d;
    logic [ADDR_W-1:0]         input_addr_q, input_addr_d;
    logic [ADDR_W-1:0]         weight_addr_q, weight_addr_d;
    logic [ADDR_W-1:0]         output_addr_q, output_addr_d;
    logic [DATA_W-1:0]         output_data_q, output_data_d;
    logic                      write_enable_q, write_enable_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic                      overflow_q, overflow_d;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   res_shift, res_relu;
    logic [DATA_W-1:0]         res_sat;
    logic                      sat_hit;
    logic [AW2-1:0]            in_full, wt_full, out_full;

    // Valid tag pipe: bit 0 marks an address issued last cycle, the top bit
    // marks the cycle its read data is on input_data/weight_data.
    assign valid_d[0] = (state_q == FETCH);
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_valid
        assign valid_d[gi] = valid_q[gi-1];
    end

    assign prod = $signed(input_data) * $signed(weight_data);

    // Result path works on acc_d so the value registered on entry to WRITE
    // already includes the final product.
    always_comb begin
        res_shift = acc_d >>> FRAC_BITS;
        res_relu  = (relu_q && res_shift[ACC_W-1]) ? '0 : res_shift;
        sat_hit   = 1'b0;
        res_sat   = res_relu[DATA_W-1:0];
        if (res_relu > SAT_MAX) begin
            res_sat = SAT_MAX[DATA_W-1:0];
            sat_hit = 1'b1;
        end else if (res_relu < SAT_MIN) begin
            res_sat = SAT_MIN[DATA_W-1:0];
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        n_d            = n_q;
        k_d            = k_q;
        relu_d         = relu_q;
        i_d            = i_q;
        j_d            = j_q;
        p_d            = p_q;
        drain_d        = drain_q;
        acc_d          = acc_q;
        input_addr_d   = input_addr_q;
        weight_addr_d  = weight_addr_q;
        output_addr_d  = output_addr_q;
        output_data_d  = output_data_q;
        write_enable_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        overflow_d     = overflow_q;

        if (valid_q[RD_LAT-1]) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d        = m;
                    n_d        = n;
                    k_d        = k;
                    relu_d     = relu_en;
                    overflow_d = 1'b0;
                    i_d        = '0;
                    j_d        = '0;
                    p_d        = '0;
                    acc_d      = '0;
                    if (m == '0 || n == '0 || k == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        busy_d  = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (p_q == k_q - 1'b1) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    state_d        = WRITE;
                    write_enable_d = 1'b1;
                    output_addr_d  = ADDR_W'(out_full);
                    output_data_d  = res_sat;
                    if (sat_hit) overflow_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            WRITE: begin
                if (i_q == m_q - 1'b1 && j_q == n_q - 1'b1) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = FETCH;
                    p_d     = '0;
                    acc_d   = '0;
                    if (j_q == n_q - 1'b1) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every cycle spent in FETCH presents the address pair for (i, j, p).
        if (state_d == FETCH) begin
            input_addr_d  = ADDR_W'(in_full);
            weight_addr_d = ADDR_W'(wt_full);
        end
    end

    always_comb begin
        in_full  = AW2'(i_d) * AW2'(k_d) + AW2'(p_d);
        wt_full  = AW2'(p_d) * AW2'(n_d) + AW2'(j_d);
        out_full = AW2'(i_q) * AW2'(n_q) + AW2'(j_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            m_q            <= '0;
            n_q            <= '0;
            k_q            <= '0;
            relu_q         <= 1'b0;
            i_q            <= '0;
            j_q            <= '0;
            p_q            <= '0;
            drain_q        <= '0;
            acc_q          <= '0;
            valid_q        <= '0;
            input_addr_q   <= '0;
            weight_addr_q  <= '0;
            output_addr_q  <= '0;
            output_data_q  <= '0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            n_q            <= n_d;
            k_q            <= k_d;
            relu_q         <= relu_d;
            i_q            <= i_d;
            j_q            <= j_d;
            p_q            <= p_d;
            drain_q        <= drain_d;
            acc_q          <= acc_d;
            valid_q        <= valid_d;
            input_addr_q   <= input_addr_d;
            weight_addr_q  <= weight_addr_d;
            output_addr_q  <= output_addr_d;
            output_data_q  <= output_data_d;
            write_enable_q <= write_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign input_addr   = input_addr_q;
    assign weight_addr  = weight_addr_q;
    assign output_addr  = output_addr_q;
    assign output_data  = output_data_q;
    assign write_enable = write_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
- Parametrised, pipelined successor to the team's single-cycle-per-step matrix multiplier.
- Computes the signed fixed-point product C[m×n] = A[m×k] · B[k×n] by streaming operands from two synchronous-read memories. Element addresses are row-major.
- Each result is written to an output memory after optional ReLU and saturation.
- Sits between the layer sequencer (start/done) and the activation/weight/output RAMs of the NN datapath.

Parameters:
- DATA_W, 16: signed operand and result width.
- ACC_W, 40: signed accumulator width; must be ≥ 2*DATA_W.
- DIM_W, 10: width of the m/n/k dimension inputs.
- ADDR_W, 16: memory address width; addresses are truncated to this width.
- RD_LAT, 1: memory read latency in cycles, range 1..3.
- FRAC_BITS, 8: fractional bits of the Q format; 0 gives integer mode.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin operation; accepted only while busy=0
- m  in  DIM_W  rows of A; latched at start
- n  in  DIM_W  columns of B; latched at start
- k  in  DIM_W  columns of A / rows of B; latched at start
- relu_en  in  1  clamp negative results to 0; latched at start
- input_addr  out  ADDR_W  A read address
- input_data  in  DATA_W  A read data, signed, valid RD_LAT cycles after address
- weight_addr  out  ADDR_W  B read address
- weight_data  in  DATA_W  B read data, signed, valid RD_LAT cycles after address
- output_addr  out  ADDR_W  C write address
- output_data  out  DATA_W  C write data, signed
- write_enable  out  1  one-cycle write strobe per result element
- busy  out  1  high from the start-accept edge to the done edge
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky; set if any result saturated; cleared on start accept

Behaviour:
- Reset (async, any state, including mid-operation):
  - state → IDLE; all outputs → 0; internal counters and accumulator → 0.
  - No write is issued after reset asserts; results already written are not rolled back.
- States: IDLE, FETCH, DRAIN, WRITE, FINISH.
- IDLE:
  - On start=1 at a clk edge: latch m, n, k and relu_en; clear overflow; busy←1; i=j=p=0; present input_addr=0, weight_addr=0.
  - If any of m, n, k is 0, go to FINISH instead; no writes occur.
  - Otherwise go to FETCH.
- start while busy=1 is ignored; dimension/mode input changes while busy have no effect.
- FETCH: one address pair issued per cycle.
  - input_addr = i*k+p; weight_addr = p*n+j.
  - p increments each cycle; after p=k-1 is issued, go to DRAIN.
- Accumulation:
  - A valid shift register of depth RD_LAT tags returning data.
  - acc is cleared when element address 0 (p=0) is issued.
  - acc += sign-extended (input_data*weight_data) on each valid return.
  - Product width is 2*DATA_W, full precision; acc wraps at ACC_W (it does not saturate).
- DRAIN: wait until the valid pipe is empty (RD_LAT cycles), then go to WRITE.
- WRITE: one cycle.
  - r = acc >>> FRAC_BITS (arithmetic shift, truncate toward −inf).
  - If relu_en and r<0, r=0.
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; on saturation set overflow.
  - output_addr = i*n+j; output_data = r; write_enable=1.
  - Advance j; at j=n−1 wrap j to 0 and increment i.
  - If the element was (m−1, n−1), go to FINISH; else go to FETCH with p=0.
- FINISH: done=1 and busy=0 on the same cycle; go to IDLE next cycle. overflow holds its value.
- Latency:
  - Cycles per element = k + RD_LAT + 1.
  - done is asserted m*n*(k+RD_LAT+1)+1 cycles after the start-accept edge.
  - Zero-dimension case: done asserted 1 cycle after start accept.
- output_addr and output_data hold their last values when write_enable=0.
- Address arithmetic is computed at DIM_W*2 width and truncated to ADDR_W; products larger than 2^ADDR_W alias without error.

Test Plan:
- Integer mode (FRAC_BITS=0, RD_LAT=1), m=n=k=2, A=[1,2;3,4], B=[5,6;7,8] → writes 19,22,43,50 to addr 0..3 in order; done 17 cycles after start accept; overflow=0.
- Same dimensions, A=[−1,2;3,−4], B=[5,6;7,8]:
  - relu_en=0 → results 9,10,−13,−14.
  - relu_en=1 → results 9,10,0,0.
- FRAC_BITS=0, m=n=k=1, A=200, B=200 → output_data=32767, overflow=1.
  - Next start with A=1, B=1 → output 1 and overflow cleared to 0.
- Q8.8 mode, RD_LAT=2, m=1, n=1, k=3:
  - A=[0x0180,0x0100,0xFF00] (1.5, 1.0, −1.0), B=[0x0200,0x0100,0x0100] (2.0, 1.0, 1.0) → output 0x0300 (3.0).
  - done 7 cycles after start accept.
- k=0 with start → no write_enable, done pulses 1 cycle after accept. A second start pulse while busy during a 2×2×2 run → ignored; result set unchanged.
- rst asserted during FETCH of element 2 of a 2×2×2 run → all outputs 0 immediately; no further writes; a new start runs the full job correctly.
